// File: rtl/swap_sequencer.sv
// swap_sequencer: periodic swap toggle generator with host config and run control.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_valid/ready : config handshake; cfg_period (P) and cfg_toggles (N, 0 = forever)
//   start/stop/pause: sequence control (priority rst > stop > pause > start)
//   swap            : toggles every P+1 clocks while running
//   tick            : high in the cycle swap holds its new value
//   busy            : high in RUN and PAUSE
//   done            : one-cycle pulse on entry to DONE
module swap_sequencer #(
   parameter int unsigned CW         = 6,
   parameter int unsigned TW         = 4,
   parameter int unsigned DEF_PERIOD = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_period,
   input  logic [TW-1:0] cfg_toggles,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   output logic          swap,
   output logic          tick,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] count, count_n;
   logic [CW-1:0] period, period_n;
   logic [TW-1:0] toggles, toggles_n;
   logic [TW-1:0] remaining, remaining_n;
   logic          swap_n, tick_n, busy_n, done_n, ready_n;
   logic          cfg_take;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         period    <= CW'(DEF_PERIOD);
         toggles   <= '0;
         remaining <= '0;
         swap      <= 1'b0;
         tick      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_n;
         count     <= count_n;
         period    <= period_n;
         toggles   <= toggles_n;
         remaining <= remaining_n;
         swap      <= swap_n;
         tick      <= tick_n;
         busy      <= busy_n;
         done      <= done_n;
         cfg_ready <= ready_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      count_n     = count;
      period_n    = period;
      toggles_n   = toggles;
      remaining_n = remaining;
      swap_n      = swap;
      tick_n      = 1'b0;
      done_n      = 1'b0;
      cfg_take    = cfg_valid & cfg_ready;

      if (cfg_take) begin
         period_n  = cfg_period;
         toggles_n = cfg_toggles;
      end

      case (state)
         IDLE, DONE: begin
            // stop and pause outrank start even when they have no effect here.
            if (start && !stop && !pause) begin
               state_n     = RUN;
               count_n     = '0;
               swap_n      = 1'b0;
               remaining_n = cfg_take ? cfg_toggles : toggles;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = IDLE;
               count_n = '0;
               swap_n  = 1'b0;
            end else if (pause) begin
               state_n = PAUSE;
            end else if (count != period) begin
               count_n = count + CW'(1);
            end else begin
               count_n = '0;
               swap_n  = ~swap;
               tick_n  = 1'b1;
               if (toggles != '0) remaining_n = remaining - TW'(1);
               // remaining stays 0 in run-forever mode, so this never fires there.
               if (remaining == TW'(1)) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               state_n = IDLE;
               count_n = '0;
               swap_n  = 1'b0;
            end else if (!pause) begin
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n  = (state_n == RUN) || (state_n == PAUSE);
      ready_n = !busy_n;
   end

endmodule

// File: tb/tb_swap_sequencer.sv
// tb_swap_sequencer: directed stimulus, a cycle-level behavioural model compared on
// every cycle, and hand-computed literal checks at the key edges.
module tb_swap_sequencer;

   localparam int unsigned CW = 6;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [CW-1:0] cfg_period = '0;
   logic [TW-1:0] cfg_toggles = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          swap, tick, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   swap_sequencer #(.CW(CW), .TW(TW), .DEF_PERIOD(30)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_toggles(cfg_toggles),
      .start(start), .stop(stop), .pause(pause),
      .swap(swap), .tick(tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 idle, 1 run, 2 paused, 3 done. Progress is tracked as active cycles
   // elapsed since start; toggles happen on multiples of P+1.
   int m_mode, m_period, m_toggles, m_target, m_elapsed, m_flips;
   int e_swap, e_tick, e_done;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      int p, t;
      bit accept;
      if (rst) begin
         m_mode = 0; m_period = 30; m_toggles = 0; m_target = 0;
         m_elapsed = 0; m_flips = 0;
         e_swap = 0; e_tick = 0; e_done = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         accept = cfg_valid && (m_mode == 0 || m_mode == 3);
         p = accept ? int'(cfg_period)  : m_period;
         t = accept ? int'(cfg_toggles) : m_toggles;
         if (accept) begin m_period = p; m_toggles = t; end
         e_tick = 0;
         e_done = 0;
         case (m_mode)
            0, 3: if (start && !stop && !pause) begin
               m_mode = 1; m_elapsed = 0; m_flips = 0; e_swap = 0; m_target = t;
            end
            1: if (stop) begin
               m_mode = 0; e_swap = 0;
            end else if (pause) begin
               m_mode = 2;
            end else begin
               m_elapsed++;
               if (m_elapsed % (m_period + 1) == 0) begin
                  m_flips++;
                  e_swap = m_flips % 2;
                  e_tick = 1;
                  if (m_target != 0 && m_flips == m_target) begin
                     m_mode = 3; e_done = 1;
                  end
               end
            end
            default: if (stop) begin
               m_mode = 0; e_swap = 0;
            end else if (!pause) begin
               m_mode = 1;
            end
         endcase
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_swap",  int'(swap),      e_swap);
         check("model_tick",  int'(tick),      e_tick);
         check("model_done",  int'(done),      e_done);
         check("model_busy",  int'(busy),      int'(m_mode == 1 || m_mode == 2));
         check("model_ready", int'(cfg_ready), int'(m_mode == 0 || m_mode == 3));
      end
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input int p, input int t);
      cfg_valid = 1'b1; cfg_period = CW'(p); cfg_toggles = TW'(t);
      adv(1);
      cfg_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      adv(1);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      adv(1);
      stop = 1'b0;
   endtask

   initial begin
      adv(2);
      rst = 1'b0;
      check("rst_swap",  int'(swap), 0);
      check("rst_tick",  int'(tick), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_done",  int'(done), 0);
      check("rst_ready", int'(cfg_ready), 1);

      // Defaults: toggles at +31, +62, +93.
      do_start();
      adv(30); check("t1_swap_30", int'(swap), 0); check("t1_busy", int'(busy), 1);
      adv(1);  check("t1_swap_31", int'(swap), 1); check("t1_tick_31", int'(tick), 1);
      adv(30); check("t1_tick_61", int'(tick), 0);
      adv(1);  check("t1_swap_62", int'(swap), 0); check("t1_tick_62", int'(tick), 1);
      adv(31); check("t1_swap_93", int'(swap), 1); check("t1_done", int'(done), 0);
      do_stop();
      check("t1_stop_busy", int'(busy), 0);

      // P=3, N=2: done at +8.
      do_cfg(3, 2);
      do_start();
      adv(3); check("t2_swap_3", int'(swap), 0);
      adv(1); check("t2_swap_4", int'(swap), 1); check("t2_tick_4", int'(tick), 1);
      adv(3); check("t2_swap_7", int'(swap), 1); check("t2_done_7", int'(done), 0);
      adv(1); check("t2_swap_8", int'(swap), 0); check("t2_done_8", int'(done), 1);
      check("t2_ready_8", int'(cfg_ready), 1); check("t2_busy_8", int'(busy), 0);
      adv(1); check("t2_done_9", int'(done), 0); check("t2_swap_9", int'(swap), 0);

      // P=3 forever, pause at count 2 for 10 edges.
      do_cfg(3, 0);
      do_start();
      adv(2);
      pause = 1'b1;
      adv(10);
      check("t3_pause_swap", int'(swap), 0); check("t3_pause_busy", int'(busy), 1);
      pause = 1'b0;
      adv(2); check("t3_swap_r1", int'(swap), 0); check("t3_tick_r1", int'(tick), 0);
      adv(1); check("t3_swap_r2", int'(swap), 1); check("t3_tick_r2", int'(tick), 1);

      // stop together with pause.
      stop = 1'b1; pause = 1'b1;
      adv(1);
      stop = 1'b0; pause = 1'b0;
      check("t4_swap", int'(swap), 0); check("t4_busy", int'(busy), 0);
      check("t4_done", int'(done), 0); check("t4_ready", int'(cfg_ready), 1);

      // P=0: toggle on every edge, tick held high.
      do_cfg(0, 0);
      do_start();
      adv(1); check("p0_swap_1", int'(swap), 1); check("p0_tick_1", int'(tick), 1);
      adv(1); check("p0_swap_2", int'(swap), 0); check("p0_tick_2", int'(tick), 1);
      adv(1); check("p0_swap_3", int'(swap), 1); check("p0_tick_3", int'(tick), 1);
      do_stop();
      do_cfg(0, 3);
      do_start();
      adv(3); check("p0n3_done", int'(done), 1); check("p0n3_swap", int'(swap), 1);

      // Reset mid-run restores the default period.
      do_cfg(2, 0);
      do_start();
      adv(5);
      rst = 1'b1;
      adv(1);
      rst = 1'b0;
      check("t5_swap", int'(swap), 0); check("t5_tick", int'(tick), 0);
      check("t5_busy", int'(busy), 0); check("t5_ready", int'(cfg_ready), 1);
      do_start();
      adv(30); check("t5_swap_30", int'(swap), 0);
      adv(1);  check("t5_swap_31", int'(swap), 1);

      // Config offered while running is ignored.
      cfg_valid = 1'b1; cfg_period = CW'(5); cfg_toggles = TW'(0);
      check("t6_ready_run", int'(cfg_ready), 0);
      adv(1);
      cfg_valid = 1'b0;
      adv(29); check("t6_swap_61", int'(swap), 1);
      adv(1);  check("t6_swap_62", int'(swap), 0); check("t6_tick_62", int'(tick), 1);
      do_stop();
      check("t6_ready_idle", int'(cfg_ready), 1);
      do_cfg(5, 0);
      do_start();
      adv(5); check("t6_swap_5", int'(swap), 0);
      adv(1); check("t6_swap_6", int'(swap), 1); check("t6_tick_6", int'(tick), 1);
      do_stop();
      adv(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
